operand_fetch: RTL and testbench

Operand-fetch stage directly upstream of the asynchronous register file. Accepts one decoded instruction at a time, issues up to three serialized register reads over the register file's read_enable / req-ack interface, captures the returned data, and presents a complete operand bundle to the execute stage with a valid/ready handshake. A per-read timeout guards against a register file that never acknowledges.

---
 rtl/operand_fetch_pkg.sv | 28 ++
 rtl/operand_fetch_if.sv | 40 ++++
 rtl/operand_fetch_hs_timeout.sv | 28 ++
 rtl/operand_fetch.sv | 125 ++++++++++++
 tb/tb_operand_fetch.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared types and constants for the operand-fetch stage.
package operand_fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_BUSY,
      S_DONE
   } state_t;

   localparam int NUM_OPS = 3;
   localparam int OP_1    = 0;
   localparam int OP_2    = 1;
   localparam int OP_3    = 2;
   localparam int TAG_W   = 8;
   localparam int ADDR_W  = 4;

   // Reads are issued strictly in operand order, so the lowest pending bit wins.
   function automatic logic [1:0] lowest_op(input logic [NUM_OPS-1:0] mask);
      if (mask[OP_1])
         return 2'(OP_1);
      else if (mask[OP_2])
         return 2'(OP_2);
      else
         return 2'(OP_3);
   endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode, register-file and execute-side signals of the operand-fetch stage.
interface operand_fetch_if
   import operand_fetch_pkg::*;
#(
   parameter int N = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [ADDR_W-1:0]  in_addr_1, in_addr_2, in_addr_3;
   logic [NUM_OPS-1:0] in_use;
   logic [TAG_W-1:0]   in_tag;

   logic               rf_read_enable_1, rf_read_enable_2, rf_read_enable_3;
   logic [ADDR_W-1:0]  rf_in_address_1, rf_in_address_2, rf_in_address_3;
   logic [N-1:0]       rf_out_data_1, rf_out_data_2, rf_out_data_3;
   logic               rf_ack;

   logic               out_valid;
   logic               out_ready;
   logic [N-1:0]       out_op_1, out_op_2, out_op_3;
   logic [TAG_W-1:0]   out_tag;
   logic               out_err;

   modport master (
      input  in_valid, in_addr_1, in_addr_2, in_addr_3, in_use, in_tag,
      input  rf_out_data_1, rf_out_data_2, rf_out_data_3, rf_ack, out_ready,
      output in_ready, rf_read_enable_1, rf_read_enable_2, rf_read_enable_3,
      output rf_in_address_1, rf_in_address_2, rf_in_address_3,
      output out_valid, out_op_1, out_op_2, out_op_3, out_tag, out_err
   );

   modport slave (
      output in_valid, in_addr_1, in_addr_2, in_addr_3, in_use, in_tag,
      output rf_out_data_1, rf_out_data_2, rf_out_data_3, rf_ack, out_ready,
      input  in_ready, rf_read_enable_1, rf_read_enable_2, rf_read_enable_3,
      input  rf_in_address_1, rf_in_address_2, rf_in_address_3,
      input  out_valid, out_op_1, out_op_2, out_op_3, out_tag, out_err
   );

endinterface

// File: rtl/operand_fetch_hs_timeout.sv
// Per-phase handshake watchdog: down-counter loaded on clear, expires at terminal count.
module hs_timeout #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= LOAD;
      else if (en && (count != '0))
         count <= count - CW'(1);
   end

   // Terminal count is reached on the TIMEOUT-th cycle of the phase.
   assign expired = en && (count == '0);

endmodule

// File: rtl/operand_fetch.sv
// Serializes up to three register-file reads per instruction and hands the operand bundle to execute.
//  state  | meaning
//  S_IDLE | ready for a decoded instruction
//  S_REQ  | read enable up, waiting for register file to go busy (ack=0)
//  S_BUSY | read in flight, waiting for ack=1 to capture data
//  S_DONE | bundle valid, waiting for execute to take it
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int N       = 32,
   parameter int TIMEOUT = 64
) (
   input logic            clk,
   input logic            rst,
   operand_fetch_if.master bus
);
   state_t             state, state_n;
   logic [NUM_OPS-1:0] pend_q, pend_left;
   logic [ADDR_W-1:0]  addr_q [NUM_OPS];
   logic [N-1:0]       op_q   [NUM_OPS];
   logic [N-1:0]       rf_data[NUM_OPS];
   logic [TAG_W-1:0]   tag_q;
   logic               err_q;
   logic [1:0]         sel;
   logic               accept, capture, abort;
   logic               rd_active, tmo_clear, tmo_expired;

   assign sel        = lowest_op(pend_q);
   assign pend_left  = pend_q & ~(NUM_OPS'(1) << sel);
   assign rf_data[OP_1] = bus.rf_out_data_1;
   assign rf_data[OP_2] = bus.rf_out_data_2;
   assign rf_data[OP_3] = bus.rf_out_data_3;

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      capture = 1'b0;
      abort   = 1'b0;
      case (state)
         S_IDLE: if (bus.in_valid) begin
            accept  = 1'b1;
            state_n = (bus.in_use == '0) ? S_DONE : S_REQ;
         end
         // ack already low on entry means another requester holds the file; treat as accepted.
         S_REQ: if (!bus.rf_ack) begin
            state_n = S_BUSY;
         end else if (tmo_expired) begin
            abort   = 1'b1;
            state_n = S_DONE;
         end
         S_BUSY: if (bus.rf_ack) begin
            capture = 1'b1;
            state_n = (pend_left != '0) ? S_REQ : S_DONE;
         end else if (tmo_expired) begin
            abort   = 1'b1;
            state_n = S_DONE;
         end
         S_DONE: if (bus.out_ready) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q <= '0;
         tag_q  <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < NUM_OPS; i++) begin
            addr_q[i] <= '0;
            op_q[i]   <= '0;
         end
      end else begin
         if (accept) begin
            pend_q       <= bus.in_use;
            tag_q        <= bus.in_tag;
            err_q        <= 1'b0;
            addr_q[OP_1] <= bus.in_addr_1;
            addr_q[OP_2] <= bus.in_addr_2;
            addr_q[OP_3] <= bus.in_addr_3;
            for (int i = 0; i < NUM_OPS; i++) op_q[i] <= '0;
         end
         if (capture) begin
            op_q[sel] <= rf_data[sel];
            pend_q    <= pend_left;
         end
         if (abort) begin
            err_q  <= 1'b1;
            pend_q <= '0;
         end
      end
   end

   assign rd_active = (state == S_REQ) || (state == S_BUSY);
   assign tmo_clear = (state_n != state) && ((state_n == S_REQ) || (state_n == S_BUSY));

   hs_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clear),
      .en      (rd_active),
      .expired (tmo_expired)
   );

   assign bus.in_ready         = (state == S_IDLE);
   assign bus.out_valid        = (state == S_DONE);
   assign bus.rf_read_enable_1 = rd_active && (sel == 2'(OP_1));
   assign bus.rf_read_enable_2 = rd_active && (sel == 2'(OP_2));
   assign bus.rf_read_enable_3 = rd_active && (sel == 2'(OP_3));
   assign bus.rf_in_address_1  = addr_q[OP_1];
   assign bus.rf_in_address_2  = addr_q[OP_2];
   assign bus.rf_in_address_3  = addr_q[OP_3];
   assign bus.out_op_1         = op_q[OP_1];
   assign bus.out_op_2         = op_q[OP_2];
   assign bus.out_op_3         = op_q[OP_3];
   assign bus.out_tag          = tag_q;
   assign bus.out_err          = err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural register-file model.
module tb_operand_fetch;
   import operand_fetch_pkg::*;

   localparam int N   = 32;
   localparam int TMO = 16;
   localparam logic [N-1:0] GARB = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   operand_fetch_if #(.N(N)) bus();
   operand_fetch #(.N(N), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   logic [N-1:0] mem [16];
   logic rf_stuck = 1'b0;
   int   lat = 12;

   // Register-file model: goes busy the cycle after a request, acks lat cycles later with mem data.
   initial begin : rf_model
      int served;
      int cnt;
      logic [2:0] en;
      served = 0;
      cnt    = 0;
      bus.rf_ack = 1'b1;
      bus.rf_out_data_1 = GARB;
      bus.rf_out_data_2 = GARB;
      bus.rf_out_data_3 = GARB;
      forever begin
         @(posedge clk);
         #1;
         en = {bus.rf_read_enable_3, bus.rf_read_enable_2, bus.rf_read_enable_1};
         if (rst || rf_stuck) begin
            bus.rf_ack = 1'b1;
            served = 0;
         end else if (served == 0) begin
            if (en != 3'b000) begin
               served = en[0] ? 1 : (en[1] ? 2 : 3);
               bus.rf_ack = 1'b0;
               cnt = lat;
            end
         end else if (!bus.rf_ack) begin
            cnt--;
            if (cnt == 0) begin
               bus.rf_ack = 1'b1;
               case (served)
                  1: bus.rf_out_data_1 = mem[bus.rf_in_address_1];
                  2: bus.rf_out_data_2 = mem[bus.rf_in_address_2];
                  default: bus.rf_out_data_3 = mem[bus.rf_in_address_3];
               endcase
            end
         end else if (!en[served-1]) begin
            served = 0;
            bus.rf_out_data_1 = GARB;
            bus.rf_out_data_2 = GARB;
            bus.rf_out_data_3 = GARB;
         end
      end
   end

   // Enable monitor: cumulative cycle counts, rising edges, issue order and overlap.
   int en_cyc [3];
   int en_rise[3];
   int overlap;
   int order_q[$];
   initial begin : en_mon
      logic [2:0] en, prev;
      prev = 3'b000;
      overlap = 0;
      for (int k = 0; k < 3; k++) begin
         en_cyc[k]  = 0;
         en_rise[k] = 0;
      end
      forever begin
         @(posedge clk);
         #2;
         en = {bus.rf_read_enable_3, bus.rf_read_enable_2, bus.rf_read_enable_1};
         if ($countones(en) > 1) overlap++;
         for (int k = 0; k < 3; k++) begin
            if (en[k]) en_cyc[k]++;
            if (en[k] && !prev[k]) begin
               en_rise[k]++;
               order_q.push_back(k + 1);
            end
         end
         prev = en;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] u, input logic [3:0] a1, input logic [3:0] a2,
                        input logic [3:0] a3, input logic [7:0] tag);
      chk("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_use    = u;
      bus.in_addr_1 = a1;
      bus.in_addr_2 = a2;
      bus.in_addr_3 = a3;
      bus.in_tag    = tag;
      @(negedge clk);
      bus.in_valid  = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!bus.out_valid && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(bus.out_valid), 32'd1);
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
   endtask

   int r0, r1, r2, q0, ov0, c0, n;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0BAD_0000 | 32'(i);
      mem[1] = 32'h0000_000A;
      mem[2] = 32'h0000_000B;
      mem[3] = 32'h0000_000C;
      mem[7] = 32'h0000_1234;
      bus.in_valid  = 1'b0;
      bus.in_use    = 3'b000;
      bus.in_addr_1 = '0;
      bus.in_addr_2 = '0;
      bus.in_addr_3 = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_enables", 32'({bus.rf_read_enable_3, bus.rf_read_enable_2, bus.rf_read_enable_1}), 32'd0);
      chk("rst_addrs", 32'({bus.rf_in_address_3, bus.rf_in_address_2, bus.rf_in_address_1}), 32'd0);
      chk("rst_ops", bus.out_op_1 | bus.out_op_2 | bus.out_op_3, 32'd0);
      chk("rst_tag_err", 32'({bus.out_tag, bus.out_err}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // all three operands
      r0 = en_rise[0]; r1 = en_rise[1]; r2 = en_rise[2];
      q0 = order_q.size(); ov0 = overlap;
      issue(3'b111, 4'd1, 4'd2, 4'd3, 8'h11);
      chk("t1_in_ready_busy", 32'(bus.in_ready), 32'd0);
      wait_valid("t1_wait_valid");
      chk("t1_op1", bus.out_op_1, 32'h0000_000A);
      chk("t1_op2", bus.out_op_2, 32'h0000_000B);
      chk("t1_op3", bus.out_op_3, 32'h0000_000C);
      chk("t1_err", 32'(bus.out_err), 32'd0);
      chk("t1_tag", 32'(bus.out_tag), 32'h11);
      chk("t1_rises", 32'({8'(en_rise[0]-r0), 8'(en_rise[1]-r1), 8'(en_rise[2]-r2)}), 32'h01_01_01);
      chk("t1_order_len", 32'(order_q.size() - q0), 32'd3);
      if (order_q.size() - q0 == 3)
         chk("t1_order", 32'({8'(order_q[q0]), 8'(order_q[q0+1]), 8'(order_q[q0+2])}), 32'h01_02_03);
      chk("t1_overlap", 32'(overlap - ov0), 32'd0);
      handshake();

      // no operands used
      r0 = en_rise[0]; r1 = en_rise[1]; r2 = en_rise[2];
      issue(3'b000, 4'd1, 4'd2, 4'd3, 8'h5A);
      chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_tag", 32'(bus.out_tag), 32'h5A);
      chk("t2_ops", bus.out_op_1 | bus.out_op_2 | bus.out_op_3, 32'd0);
      chk("t2_no_enables", 32'((en_rise[0]-r0) + (en_rise[1]-r1) + (en_rise[2]-r2)), 32'd0);
      handshake();

      // only operand 3
      r0 = en_rise[0]; r1 = en_rise[1]; r2 = en_rise[2];
      issue(3'b100, 4'd0, 4'd0, 4'd7, 8'h34);
      wait_valid("t3_wait_valid");
      chk("t3_op3", bus.out_op_3, 32'h0000_1234);
      chk("t3_op12", bus.out_op_1 | bus.out_op_2, 32'd0);
      chk("t3_rises", 32'({8'(en_rise[0]-r0), 8'(en_rise[1]-r1), 8'(en_rise[2]-r2)}), 32'h00_00_01);

      // back-pressure: bundle held, second instruction waits for the handshake
      bus.in_valid = 1'b1;
      bus.in_use   = 3'b000;
      bus.in_tag   = 8'h77;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
         chk("t4_hold_in_ready", 32'(bus.in_ready), 32'd0);
         chk("t4_hold_bundle", 32'({bus.out_tag, bus.out_op_3[23:0]}), 32'h34_001234);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("t4_in_ready_after", 32'(bus.in_ready), 32'd1);
      chk("t4_valid_dropped", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("t4_second_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_second_tag", 32'(bus.out_tag), 32'h77);
      handshake();

      // register file never goes busy
      rf_stuck = 1'b1;
      c0 = en_cyc[0];
      issue(3'b001, 4'd5, 4'd0, 4'd0, 8'h66);
      wait_valid("t5_wait_valid");
      chk("t5_enable_cycles", 32'(en_cyc[0] - c0), 32'd16);
      chk("t5_err", 32'(bus.out_err), 32'd1);
      chk("t5_op1", bus.out_op_1, 32'd0);
      chk("t5_tag", 32'(bus.out_tag), 32'h66);
      handshake();
      rf_stuck = 1'b0;

      // reset during the busy phase of operand 2
      issue(3'b111, 4'd1, 4'd2, 4'd3, 8'h99);
      n = 0;
      while (!(bus.rf_read_enable_2 && !bus.rf_ack) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t6_reached_busy2", 32'(bus.rf_read_enable_2 && !bus.rf_ack), 32'd1);
      chk("t6_op1_before", bus.out_op_1, 32'h0000_000A);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_enables", 32'({bus.rf_read_enable_3, bus.rf_read_enable_2, bus.rf_read_enable_1}), 32'd0);
      chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
      chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
      chk("t6_op1", bus.out_op_1, 32'd0);
      chk("t6_tag_err", 32'({bus.out_tag, bus.out_err}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // clean transaction after reset
      issue(3'b010, 4'd0, 4'd3, 4'd0, 8'h21);
      wait_valid("t7_wait_valid");
      chk("t7_op2", bus.out_op_2, 32'h0000_000C);
      chk("t7_err", 32'(bus.out_err), 32'd0);
      handshake();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
